montgomery_batch_sched: RTL and testbench

//  Sequences one montgomery_ds reduction core over a batch of operands, e.g. the 256

---
 rtl/multiplier_pkg.sv | 18 +
 rtl/montgomery_batch_sched.sv | 167 ++++++++++++++++
 tb/tb_montgomery_batch_sched.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_pkg.sv
// Shared types and constants for the Montgomery batch scheduler.
package multiplier_pkg;

    localparam int DATA_LENGTH        = 32;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int TIMEOUT_W          = $clog2(TIMEOUT_CYCLES_DEF + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } sched_state_e;

endpackage

// File: rtl/montgomery_batch_sched.sv
// Drives one Montgomery reduction core over a batch of operands, one operand in flight,
// emitting each result with its batch index and a last flag.
module montgomery_batch_sched
    import multiplier_pkg::*;
#(
    parameter int IDX_W          = 8,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_ni,
    input  logic [DATA_LENGTH-1:0] cfg_m_i,
    input  logic [DATA_LENGTH-1:0] cfg_minv_i,
    input  logic [DATA_LENGTH-1:0] cfg_m_bl_i,
    input  logic                   batch_start_i,
    input  logic [IDX_W-1:0]       batch_len_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_LENGTH-1:0] in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_LENGTH-1:0] out_data_o,
    output logic [IDX_W-1:0]       out_idx_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   batch_done_o,
    output logic                   timeout_o,
    output logic                   core_start_o,
    output logic [DATA_LENGTH-1:0] core_x_o,
    output logic [DATA_LENGTH-1:0] core_m_o,
    output logic [DATA_LENGTH-1:0] core_minv_o,
    output logic [DATA_LENGTH-1:0] core_m_bl_o,
    input  logic [DATA_LENGTH-1:0] core_result_i,
    input  logic                   core_valid_i,
    output sched_state_e           dbg_state_o
);

    // Both streams: a beat transfers on a rising edge where valid and ready are both
    // high; a producer holding valid keeps its data stable until that transfer.

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       len_q, len_d, idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] x_q, x_d, m_q, m_d, minv_q, minv_d, mbl_q, mbl_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic                   in_ready_q, in_ready_d, start_q, start_d;
    logic                   oval_q, oval_d, last_q, last_d;
    logic                   busy_q, busy_d, done_q, done_d, tout_q, tout_d;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        m_d     = m_q;
        minv_d  = minv_q;
        mbl_d   = mbl_q;
        data_d  = data_q;
        tout_d  = tout_q;
        unique case (state_q)
            IDLE, ERROR: begin
                if (batch_start_i) begin
                    m_d     = cfg_m_i;
                    minv_d  = cfg_minv_i;
                    mbl_d   = cfg_m_bl_i;
                    len_d   = batch_len_i;
                    idx_d   = '0;
                    tout_d  = 1'b0;
                    state_d = (batch_len_i == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid_i && in_ready_q) begin
                    x_d     = in_data_i;
                    state_d = START;
                end
            end
            START: begin
                // cnt counts cycles elapsed since the start pulse
                cnt_d   = CNT_W'(1);
                state_d = WAIT;
            end
            WAIT: begin
                if (core_valid_i) begin
                    data_d  = core_result_i;
                    state_d = OUT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready_i) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = (idx_q == len_q - IDX_ONE) ? DONE : LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == LOAD);
        start_d    = (state_d == START);
        oval_d     = (state_d == OUT);
        last_d     = (state_d == OUT) && (idx_d == len_q - IDX_ONE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            x_q        <= '0;
            m_q        <= '0;
            minv_q     <= '0;
            mbl_q      <= '0;
            data_q     <= '0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b0;
            oval_q     <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            m_q        <= m_d;
            minv_q     <= minv_d;
            mbl_q      <= mbl_d;
            data_q     <= data_d;
            in_ready_q <= in_ready_d;
            start_q    <= start_d;
            oval_q     <= oval_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tout_q     <= tout_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = oval_q;
    assign out_data_o   = data_q;
    assign out_idx_o    = idx_q;
    assign out_last_o   = last_q;
    assign busy_o       = busy_q;
    assign batch_done_o = done_q;
    assign timeout_o    = tout_q;
    assign core_start_o = start_q;
    assign core_x_o     = x_q;
    assign core_m_o     = m_q;
    assign core_minv_o  = minv_q;
    assign core_m_bl_o  = mbl_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_montgomery_batch_sched.sv
// Randomized bench for montgomery_batch_sched: reduction core stub, cycle model, literal pins.
module tb_montgomery_batch_sched;
  import multiplier_pkg::*;

  localparam int DL = DATA_LENGTH;
  localparam int IW = 8;
  localparam int T  = TIMEOUT_CYCLES_DEF;
  localparam logic [DL-1:0] Q = 32'd8380417;

  logic clk, rst_n;
  logic [DL-1:0] cfg_m_i, cfg_minv_i, cfg_m_bl_i, in_data_i, core_result_i;
  logic [DL-1:0] out_data_o, core_x_o, core_m_o, core_minv_o, core_m_bl_o;
  logic [IW-1:0] batch_len_i, out_idx_o;
  logic batch_start_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, out_last_o;
  logic busy_o, batch_done_o, timeout_o, core_start_o, core_valid_i;
  sched_state_e dbg_state;

  montgomery_batch_sched #(.IDX_W(IW), .TIMEOUT_CYCLES(T)) dut (
    .CLK_pci_sys_clk_p(clk), .rst_ni(rst_n),
    .cfg_m_i(cfg_m_i), .cfg_minv_i(cfg_minv_i), .cfg_m_bl_i(cfg_m_bl_i),
    .batch_start_i(batch_start_i), .batch_len_i(batch_len_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_idx_o(out_idx_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .batch_done_o(batch_done_o), .timeout_o(timeout_o), .core_start_o(core_start_o),
    .core_x_o(core_x_o), .core_m_o(core_m_o), .core_minv_o(core_minv_o),
    .core_m_bl_o(core_m_bl_o), .core_result_i(core_result_i),
    .core_valid_i(core_valid_i), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters, queues ----------------
  int n_vec = 0, n_fail = 0, cyc = 0;
  logic [DL-1:0] exp_q[$];
  logic [DL-1:0] op_q[$];
  logic [DL-1:0] got_d_q[$];
  logic [IW:0]   got_t_q[$];
  int n_starts, start_cyc, tout_cyc, done_cyc, bs_cyc, hs_out_cyc;
  bit tout_seen;

  // stimulus controls
  int stub_lat = 10, stub_cnt = 0, ordy_hold = 0;
  bit stub_en = 1, feed_rand = 0, ordy_rand = 0, spur = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit m_busy, m_ready, m_start, m_wait, m_oval, m_done, m_err, p_start, p_done;
  int m_len, m_idx, m_cnt;
  logic [DL-1:0] m_x, m_M, m_minv, m_bl;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ready = 0; m_start = 0; m_wait = 0; m_oval = 0; m_done = 0; m_err = 0;
      m_len = 0; m_idx = 0; m_cnt = 0; m_x = '0; m_M = '0; m_minv = '0; m_bl = '0;
      exp_q.delete();
    end else begin
      cyc++;
      chk("in_ready", 64'(in_ready_o), 64'(m_ready));
      chk("core_start", 64'(core_start_o), 64'(m_start));
      chk("out_valid", 64'(out_valid_o), 64'(m_oval));
      chk("busy", 64'(busy_o), 64'(m_busy));
      chk("batch_done", 64'(batch_done_o), 64'(m_done));
      chk("timeout", 64'(timeout_o), 64'(m_err));
      chk("out_last", 64'(out_last_o), 64'(m_oval && (m_idx == m_len - 1)));
      if (m_oval) begin
        if (exp_q.size() == 0) chk("exp_queue_empty", 64'(1), 64'(0));
        else chk("out_data", 64'(out_data_o), 64'(exp_q[0]));
        chk("out_idx", 64'(out_idx_o), 64'(m_idx));
      end
      if (m_start || m_wait) chk("core_x", 64'(core_x_o), 64'(m_x));
      if (m_busy) begin
        chk("core_m", 64'(core_m_o), 64'(m_M));
        chk("core_minv", 64'(core_minv_o), 64'(m_minv));
        chk("core_m_bl", 64'(core_m_bl_o), 64'(m_bl));
      end
      if (core_start_o) begin n_starts++; start_cyc = cyc; end
      if (timeout_o && !tout_seen) begin tout_seen = 1; tout_cyc = cyc; end
      if (batch_done_o) done_cyc = cyc;
      if (batch_start_i) bs_cyc = cyc;

      // advance the model by one cycle
      p_start = m_start; p_done = m_done; m_start = 0; m_done = 0;
      if (p_done) begin
        m_busy = 0;
      end else if (!m_busy || m_err) begin
        if (batch_start_i) begin
          m_M = cfg_m_i; m_minv = cfg_minv_i; m_bl = cfg_m_bl_i;
          m_len = int'(batch_len_i); m_idx = 0; m_err = 0; m_busy = 1;
          exp_q.delete();
          if (m_len == 0) m_done = 1; else m_ready = 1;
        end
      end else if (m_ready) begin
        if (in_valid_i) begin
          m_ready = 0; m_start = 1; m_x = in_data_i;
          exp_q.push_back(in_data_i % m_M);
        end
      end else if (p_start) begin
        m_wait = 1; m_cnt = 1;
      end else if (m_wait) begin
        if (core_valid_i) begin m_wait = 0; m_oval = 1; end
        else if (m_cnt == T - 1) begin m_wait = 0; m_err = 1; end
        else m_cnt++;
      end else if (m_oval) begin
        if (out_ready_i) begin
          m_oval = 0; hs_out_cyc = cyc;
          got_d_q.push_back(out_data_o);
          got_t_q.push_back({out_last_o, out_idx_o});
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (m_idx == m_len - 1) m_done = 1; else m_ready = 1;
          m_idx++;
        end
      end
    end
  end

  // ---------------- drivers: operand feed, output sink, core stub ----------------
  bit hs_in;
  initial begin
    in_valid_i = 0; in_data_i = '0; out_ready_i = 1; core_valid_i = 0; core_result_i = '0;
    forever begin
      @(negedge clk);
      hs_in = in_valid_i && in_ready_o && rst_n;
      @(posedge clk); #1;
      if (hs_in && op_q.size() > 0) void'(op_q.pop_front());
      if (in_valid_i && !hs_in && op_q.size() > 0) begin
        in_data_i = op_q[0];
      end else if (op_q.size() > 0 && (!feed_rand || $urandom_range(0, 3) != 0)) begin
        in_valid_i = 1; in_data_i = op_q[0];
      end else begin
        in_valid_i = 0;
      end
      if (ordy_hold > 0 && out_valid_o) begin
        out_ready_i = 0; ordy_hold--;
      end else begin
        out_ready_i = ordy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      core_valid_i = 0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0 && stub_en) begin
          core_valid_i = 1; core_result_i = core_x_o % core_m_o;
        end
      end
      if (core_start_o) stub_cnt = stub_lat;
      if (spur) begin core_valid_i = 1; core_result_i = $urandom; spur = 0; end
      if (!rst_n) begin stub_cnt = 0; core_valid_i = 0; in_valid_i = 0; end
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic start_batch(input logic [DL-1:0] m, input int len);
    @(posedge clk); #1;
    cfg_m_i = m; cfg_minv_i = $urandom; cfg_m_bl_i = 32'd23;
    batch_len_i = IW'(len); batch_start_i = 1;
    @(posedge clk); #1;
    batch_start_i = 0; cfg_m_i = $urandom; cfg_minv_i = $urandom; cfg_m_bl_i = $urandom;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk); #1;
      if (batch_done_o) seen = 1;
    end
    if (!seen) chk({name, "_done_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic clear_obs();
    got_d_q.delete(); got_t_q.delete(); n_starts = 0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_in_ready"}, 64'(in_ready_o), 0);
    chk({name, "_out_valid"}, 64'(out_valid_o), 0);
    chk({name, "_out_data"}, 64'(out_data_o), 0);
    chk({name, "_out_idx"}, 64'(out_idx_o), 0);
    chk({name, "_out_last"}, 64'(out_last_o), 0);
    chk({name, "_busy"}, 64'(busy_o), 0);
    chk({name, "_batch_done"}, 64'(batch_done_o), 0);
    chk({name, "_timeout"}, 64'(timeout_o), 0);
    chk({name, "_core_start"}, 64'(core_start_o), 0);
    chk({name, "_core_x"}, 64'(core_x_o), 0);
    chk({name, "_core_m"}, 64'(core_m_o), 0);
    chk({name, "_core_minv"}, 64'(core_minv_o), 0);
    chk({name, "_core_m_bl"}, 64'(core_m_bl_o), 0);
    chk({name, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  logic [DL-1:0] s1_ops[4] = '{32'h800001, 32'd5, 32'h7FE001, 32'h1000000};
  logic [DL-1:0] s1_exp[4] = '{32'h2000, 32'd5, 32'd0, 32'h3FFE};
  logic [DL-1:0] s6_ops[3];
  initial begin
    rst_n = 0; batch_start_i = 0; batch_len_i = '0;
    cfg_m_i = '0; cfg_minv_i = '0; cfg_m_bl_i = '0;
    repeat (3) @(posedge clk);
    #2 check_zero("reset");
    #2 rst_n = 1;

    // 1: fixed Dilithium operands, no back-pressure
    clear_obs(); stub_lat = 10;
    foreach (s1_ops[i]) op_q.push_back(s1_ops[i]);
    start_batch(Q, 4);
    wait_done("s1", 200);
    chk("s1_count", 64'(got_d_q.size()), 4);
    for (int i = 0; i < 4 && i < got_d_q.size(); i++) begin
      chk($sformatf("s1_data%0d", i), 64'(got_d_q[i]), 64'(s1_exp[i]));
      chk($sformatf("s1_tag%0d", i), 64'(got_t_q[i]), 64'((i == 3 ? 256 : 0) + i));
    end
    chk("s1_starts", 64'(n_starts), 4);
    chk("s1_done_lat", 64'(done_cyc - hs_out_cyc), 1);

    // 2: first result stalled for 20 cycles
    clear_obs(); ordy_hold = 20;
    op_q.push_back(32'(($urandom_range(0, 32'hFFFFFF)))); op_q.push_back($urandom);
    start_batch(Q, 2);
    wait_done("s2", 200);
    chk("s2_count", 64'(got_d_q.size()), 2);
    chk("s2_starts", 64'(n_starts), 2);

    // 3: empty batch
    clear_obs();
    start_batch(Q, 0);
    wait_done("s3", 10);
    chk("s3_done_lat", 64'(done_cyc - bs_cyc), 1);
    chk("s3_starts", 64'(n_starts), 0);
    chk("s3_count", 64'(got_d_q.size()), 0);

    // 4: core never answers, then recover with a fresh batch
    clear_obs(); stub_en = 0; tout_seen = 0;
    op_q.push_back($urandom);
    start_batch(Q, 1);
    for (int i = 0; i < T + 50 && !tout_seen; i++) begin @(negedge clk); #1; end
    chk("s4_timeout_seen", 64'(tout_seen), 1);
    chk("s4_timeout_lat", 64'(tout_cyc - start_cyc), 64'(T));
    chk("s4_in_ready", 64'(in_ready_o), 0);
    stub_en = 1; clear_obs();
    repeat (3) op_q.push_back($urandom);
    start_batch(Q, 3);
    chk("s4_timeout_cleared", 64'(timeout_o), 0);
    wait_done("s4", 200);
    chk("s4_count", 64'(got_d_q.size()), 3);

    // 5: reset while waiting on the core; stale and spurious core_valid ignored
    clear_obs(); stub_lat = 10;
    repeat (3) op_q.push_back($urandom);
    start_batch(Q, 3);
    for (int i = 0; i < 20 && n_starts == 0; i++) begin @(negedge clk); #1; end
    repeat (3) @(posedge clk);
    #2 rst_n = 0;
    #1 check_zero("s5_rst");
    op_q.delete();
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1 spur = 1;
    repeat (15) @(posedge clk);
    #1 chk("s5_no_output", 64'(got_d_q.size()), 0);
    chk("s5_idle", 64'(busy_o), 0);

    // 6: batch_start mid-batch with a different modulus is ignored
    clear_obs(); stub_lat = 5;
    foreach (s6_ops[i]) begin s6_ops[i] = $urandom; op_q.push_back(s6_ops[i]); end
    start_batch(Q, 3);
    @(posedge clk); #1;
    cfg_m_i = Q - 2; batch_len_i = 8'd7; batch_start_i = 1;
    @(posedge clk); #1 batch_start_i = 0;
    wait_done("s6", 200);
    chk("s6_count", 64'(got_d_q.size()), 3);
    for (int i = 0; i < 3 && i < got_d_q.size(); i++)
      chk($sformatf("s6_data%0d", i), 64'(got_d_q[i]), 64'(s6_ops[i] % Q));

    // randomized batches
    feed_rand = 1; ordy_rand = 1;
    for (int b = 0; b < 25; b++) begin
      int len;
      logic [DL-1:0] m;
      len = $urandom_range(1, 10);
      m = 32'($urandom_range(1000, 32'h7FFFFF));
      stub_lat = $urandom_range(1, 12);
      clear_obs();
      repeat (len) op_q.push_back($urandom);
      start_batch(m, len);
      if (len >= 2) begin
        @(posedge clk); #1;
        cfg_m_i = $urandom; batch_len_i = IW'($urandom_range(0, 255)); batch_start_i = 1;
        @(posedge clk); #1 batch_start_i = 0;
      end
      wait_done("rand", 600);
      chk("rand_count", 64'(got_d_q.size()), 64'(len));
      chk("rand_starts", 64'(n_starts), 64'(len));
      if (got_t_q.size() > 0) chk("rand_last_tag", 64'(got_t_q[got_t_q.size()-1]), 64'(256 + len - 1));
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_fail);
    $fatal(1);
  end

endmodule
